// File: rtl/fp_align_add_if.sv
// Operand/result handshake bundle for the single-precision align-and-add stage.
// The slave modport is the adder's view; the master modport is the driver's.
interface fp_align_add_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [24:0] mantissa_temp;
  logic [7:0]  exp;
  logic        sign;

  modport slave (
    input  in_valid, a, b, op, out_ready,
    output in_ready, out_valid, mantissa_temp, exp, sign
  );

  modport master (
    output in_valid, a, b, op, out_ready,
    input  in_ready, out_valid, mantissa_temp, exp, sign
  );
endinterface

// File: rtl/fp_align_add.sv
// Three-stage IEEE-754 single-precision unpack/align/add front end. Produces the
// unnormalized magnitude, larger exponent and sign for a following normalizer.
module fp_align_add (
  input  logic          clk,
  input  logic          rst,
  fp_align_add_if.slave bus
);

  logic        w_en;

  logic [7:0]  w_a_exp, w_b_exp;
  logic [23:0] w_a_mant, w_b_mant;
  logic        w_a_sign, w_b_sign;
  logic        w_a_is_l;
  logic [7:0]  w_l_exp, w_s_exp;
  logic [23:0] w_l_mant, w_s_mant;
  logic        w_l_sign, w_s_sign;

  logic        r_s1_valid;
  logic [23:0] r_s1_l_mant, r_s1_s_mant;
  logic [7:0]  r_s1_l_exp, r_s1_diff;
  logic        r_s1_l_sign, r_s1_sub;

  logic [23:0] w_s2_aligned;
  logic        r_s2_valid;
  logic [23:0] r_s2_l_mant, r_s2_s_mant;
  logic [7:0]  r_s2_l_exp;
  logic        r_s2_l_sign, r_s2_sub;

  logic [24:0] w_sum;
  logic        r_out_valid;
  logic [24:0] r_mant;
  logic [7:0]  r_exp;
  logic        r_sign;

  // The whole pipe freezes only when a result is waiting and not being taken.
  assign w_en         = !(r_out_valid && !bus.out_ready);
  assign bus.in_ready = w_en;

  // Denormals flush to zero: no hidden bit and fraction ignored.
  assign w_a_exp  = bus.a[30:23];
  assign w_b_exp  = bus.b[30:23];
  assign w_a_mant = (w_a_exp != 8'd0) ? {1'b1, bus.a[22:0]} : 24'd0;
  assign w_b_mant = (w_b_exp != 8'd0) ? {1'b1, bus.b[22:0]} : 24'd0;
  assign w_a_sign = bus.a[31];
  assign w_b_sign = bus.b[31] ^ bus.op;

  assign w_a_is_l = {w_a_exp, w_a_mant[22:0]} >= {w_b_exp, w_b_mant[22:0]};
  assign w_l_exp  = w_a_is_l ? w_a_exp  : w_b_exp;
  assign w_s_exp  = w_a_is_l ? w_b_exp  : w_a_exp;
  assign w_l_mant = w_a_is_l ? w_a_mant : w_b_mant;
  assign w_s_mant = w_a_is_l ? w_b_mant : w_a_mant;
  assign w_l_sign = w_a_is_l ? w_a_sign : w_b_sign;
  assign w_s_sign = w_a_is_l ? w_b_sign : w_a_sign;

  assign w_s2_aligned = (r_s1_diff >= 8'd24) ? 24'd0 : (r_s1_s_mant >> r_s1_diff);

  // Subtraction never underflows because L has the larger magnitude.
  assign w_sum = r_s2_sub ? ({1'b0, r_s2_l_mant} - {1'b0, r_s2_s_mant})
                          : ({1'b0, r_s2_l_mant} + {1'b0, r_s2_s_mant});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_s1_l_mant <= '0;
      r_s1_s_mant <= '0;
      r_s1_l_exp  <= '0;
      r_s1_diff   <= '0;
      r_s1_l_sign <= 1'b0;
      r_s1_sub    <= 1'b0;
      r_s2_valid  <= 1'b0;
      r_s2_l_mant <= '0;
      r_s2_s_mant <= '0;
      r_s2_l_exp  <= '0;
      r_s2_l_sign <= 1'b0;
      r_s2_sub    <= 1'b0;
      r_out_valid <= 1'b0;
      r_mant      <= '0;
      r_exp       <= '0;
      r_sign      <= 1'b0;
    end else if (w_en) begin
      r_s1_valid  <= bus.in_valid;
      r_s1_l_mant <= w_l_mant;
      r_s1_s_mant <= w_s_mant;
      r_s1_l_exp  <= w_l_exp;
      r_s1_diff   <= w_l_exp - w_s_exp;
      r_s1_l_sign <= w_l_sign;
      r_s1_sub    <= w_l_sign ^ w_s_sign;

      r_s2_valid  <= r_s1_valid;
      r_s2_l_mant <= r_s1_l_mant;
      r_s2_s_mant <= w_s2_aligned;
      r_s2_l_exp  <= r_s1_l_exp;
      r_s2_l_sign <= r_s1_l_sign;
      r_s2_sub    <= r_s1_sub;

      r_out_valid <= r_s2_valid;
      r_mant      <= w_sum;
      r_exp       <= r_s2_l_exp;
      r_sign      <= (w_sum == 25'd0) ? 1'b0 : r_s2_l_sign;
    end
  end

  assign bus.out_valid     = r_out_valid;
  assign bus.mantissa_temp = r_mant;
  assign bus.exp           = r_exp;
  assign bus.sign          = r_sign;

endmodule
